// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and defaults for the PWM duty generator
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} pwm_state_t;
  localparam int PWM_WIDTH_DEF = 11;
endpackage

// File: rtl/pwm_period_cnt.sv
// rtl/pwm_period_cnt.sv - free-running period counter with terminal-count flag
module pwm_period_cnt
  import pwm_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH_DEF,
  parameter int PERIOD_M1 = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             at_tc
);
  localparam logic [WIDTH-1:0] TC = WIDTH'(PERIOD_M1);

  assign at_tc = (cnt == TC);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_tc ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_duty_gen.sv
// rtl/pwm_duty_gen.sv - complementary PWM pair with double-buffered duty, updated on period boundaries
module pwm_duty_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH_DEF,
  parameter int PERIOD_M1 = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_vld,
  output logic             duty_rdy,
  output logic             high_out,
  output logic             low_out,
  output logic             synch,
  output logic             busy
);
  localparam logic [WIDTH-1:0] TC = WIDTH'(PERIOD_M1);

  pwm_state_t       state, nextState;
  logic [WIDTH-1:0] cnt;
  logic             atTc;
  logic             cntClr, cntInc;
  logic [WIDTH-1:0] shadow, dutyAct, dutySat;
  logic             pend;
  logic             running, boundary, capture, cntBelow;

  pwm_period_cnt #(.WIDTH(WIDTH), .PERIOD_M1(PERIOD_M1)) periodCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cntClr),
    .inc   (cntInc),
    .cnt   (cnt),
    .at_tc (atTc)
  );

  assign running  = (state != IDLE);
  assign cntBelow = (cnt < dutyAct);
  assign dutySat  = (duty > TC) ? TC : duty;
  // Transfer and capture are mutually exclusive on pend, so a capture landing
  // on a boundary cycle always waits for the following boundary.
  assign boundary = pend && (!running || atTc);
  assign capture  = duty_vld && !pend;
  assign duty_rdy = ~pend;
  assign busy     = running;

  always_comb begin
    nextState = state;
    cntClr    = 1'b0;
    cntInc    = 1'b0;
    case (state)
      IDLE: begin
        cntClr = 1'b1;
        if (en) nextState = RUN;
      end
      RUN: begin
        cntInc = 1'b1;
        if (!en) nextState = STOP;
      end
      STOP: begin
        cntInc = 1'b1;
        if (en) nextState = RUN;
        else if (atTc) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      dutyAct  <= '0;
      pend     <= 1'b0;
      high_out <= 1'b0;
      low_out  <= 1'b0;
      synch    <= 1'b0;
    end else begin
      state <= nextState;
      if (boundary) begin
        dutyAct <= shadow;
        pend    <= 1'b0;
      end else if (capture) begin
        shadow <= dutySat;
        pend   <= 1'b1;
      end
      high_out <= running && cntBelow;
      low_out  <= running && !cntBelow;
      synch    <= running && (cnt == '0);
    end
  end
endmodule

// File: tb/tb_pwm_duty_gen.sv
// tb/tb_pwm_duty_gen.sv - directed and randomized bench for pwm_duty_gen against a behavioural model
module tb_pwm_duty_gen;
  localparam int W = 8;
  localparam int P = 15;

  logic         clk = 1'b0;
  logic         rst, en, duty_vld;
  logic [W-1:0] duty;
  logic         duty_rdy, high_out, low_out, synch, busy;

  int testsRun  = 0;
  int failCount = 0;

  // model: 0 idle, 1 run, 2 stop
  int mState, mCnt, mAct, mShadow;
  bit mPend, eHigh, eLow, eSynch;

  always #5 clk = ~clk;

  pwm_duty_gen #(.WIDTH(W), .PERIOD_M1(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .duty     (duty),
    .duty_vld (duty_vld),
    .duty_rdy (duty_rdy),
    .high_out (high_out),
    .low_out  (low_out),
    .synch    (synch),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    bit running, tc, below;
    if (rst) begin
      mState = 0; mCnt = 0; mAct = 0; mShadow = 0; mPend = 0;
      eHigh = 0; eLow = 0; eSynch = 0;
    end else begin
      running = (mState != 0);
      tc      = running && (mCnt == P);
      below   = (mCnt < mAct);
      eHigh   = running && below;
      eLow    = running && !below;
      eSynch  = running && (mCnt == 0);
      if (mPend && (!running || tc)) begin
        mAct  = mShadow;
        mPend = 0;
      end else if (duty_vld && !mPend) begin
        mShadow = (int'(duty) > P) ? P : int'(duty);
        mPend   = 1;
      end
      case (mState)
        0: if (en) mState = 1;
        1: if (!en) mState = 2;
        default: if (en) mState = 1; else if (tc) mState = 0;
      endcase
      mCnt = running ? (tc ? 0 : mCnt + 1) : 0;
    end
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    chk("high_out", high_out, eHigh);
    chk("low_out", low_out, eLow);
    chk("synch", synch, eSynch);
    chk("busy", busy, mState != 0);
    chk("duty_rdy", duty_rdy, !mPend);
    chk("nonoverlap", high_out & low_out, 0);
  endtask

  task automatic loadDuty(input int d);
    bit done = 0;
    duty     = W'(d);
    duty_vld = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = !mPend;
      cycle();
    end
    duty_vld = 1'b0;
    if (!done) chk("load_timeout", 0, 1);
  endtask

  task automatic waitApplied();
    for (int i = 0; i < 100 && mPend; i++) cycle();
    if (mPend) chk("apply_timeout", 0, 1);
    cycle();
  endtask

  task automatic waitCnt(input int c);
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (mState != 0 && mCnt == c) hit = 1;
      else cycle();
    end
    if (!hit) chk("cnt_timeout", 0, 1);
  endtask

  task automatic window(input string tag, input int expHigh, input int expLow, input int expSynch);
    int h = 0, l = 0, s = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      h += int'(high_out);
      l += int'(low_out);
      s += int'(synch);
    end
    chk({tag, "_high"}, h, expHigh);
    chk({tag, "_low"}, l, expLow);
    chk({tag, "_synch"}, s, expSynch);
  endtask

  initial begin
    int gap;
    rst = 1'b1; en = 1'b0; duty_vld = 1'b0; duty = '0;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (5) cycle();
    chk("idle_rdy", duty_rdy, 1);

    loadDuty(4);
    waitApplied();
    en = 1'b1;
    repeat (2) cycle();
    window("basic", 8, 24, 2);

    waitCnt(6);
    loadDuty(10);
    chk("mid_rdy_low", duty_rdy, 0);
    waitApplied();
    window("update", 20, 12, 2);

    waitCnt(2);
    loadDuty(2);
    duty = W'(12); duty_vld = 1'b1;
    repeat (3) cycle();
    duty_vld = 1'b0;
    waitApplied();
    window("b2b", 4, 28, 2);

    loadDuty(0);  waitApplied(); window("duty0", 0, 32, 2);
    loadDuty(15); waitApplied(); window("duty15", 30, 2, 2);
    loadDuty(20); waitApplied(); window("duty20", 30, 2, 2);

    waitCnt(5);
    en = 1'b0;
    for (int i = 0; i < 40 && mState != 0; i++) cycle();
    cycle();
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_high", high_out, 0);

    en = 1'b1;
    for (int i = 0; i < 40 && !synch; i++) cycle();
    chk("resume_synch_seen", synch, 1);
    gap = 0;
    for (int i = 0; i < 40; i++) begin
      if (gap == 4) en = 1'b0;
      if (gap == 7) en = 1'b1;
      cycle();
      gap++;
      if (synch) break;
    end
    chk("resume_gap", gap, 16);

    waitCnt(7);
    rst = 1'b1;
    cycle();
    chk("rst_mid_high", high_out, 0);
    chk("rst_mid_low", low_out, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      duty_vld = ($urandom_range(0, 3) == 0);
      duty     = W'($urandom_range(0, 40));
      rst      = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
